// File: rtl/router_node_pkg.sv
// Shared types for the torus router node: the flit layout, the route
// classes and the arbiter source selector.
package router_node_pkg;

    localparam int FLIT_W    = 82;
    localparam int VALID_BIT = 81;
    localparam int DST_X_HI  = 47;
    localparam int DST_X_LO  = 44;
    localparam int DST_Y_HI  = 43;
    localparam int DST_Y_LO  = 40;

    typedef struct packed {
        logic        valid;
        logic [32:0] meta;
        logic [3:0]  dst_x;
        logic [3:0]  dst_y;
        logic [7:0]  src;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic [1:0] {ROUTE_X, ROUTE_Y, ROUTE_EJECT} route_e;

    // Round-robin pointer value: which input wins the next two-way tie.
    typedef enum logic {SRC_X, SRC_Y} src_e;

    // Dimension-order routing: resolve X first, then Y, then eject.
    function automatic route_e route_of(flit_t f, logic [3:0] my_x, logic [3:0] my_y);
        if (f.dst_x != my_x)      return ROUTE_X;
        else if (f.dst_y != my_y) return ROUTE_Y;
        else                      return ROUTE_EJECT;
    endfunction

endpackage

// File: rtl/router_node_if.sv
// Flit links of one router node: the two incoming and two outgoing 82-bit links.
interface router_node_if;
    import router_node_pkg::*;

    logic [FLIT_W-1:0] in_xpos_ser;
    logic [FLIT_W-1:0] in_ypos_ser;
    logic [FLIT_W-1:0] out_xpos_ser;
    logic [FLIT_W-1:0] out_ypos_ser;

    modport master (output in_xpos_ser, output in_ypos_ser,
                    input  out_xpos_ser, input  out_ypos_ser);
    modport slave  (input  in_xpos_ser, input  in_ypos_ser,
                    output out_xpos_ser, output out_ypos_ser);
endinterface

// File: rtl/router_node_fifo.sv
// Per-input flit FIFO; a pop in the same cycle frees the slot a full-FIFO push needs.
module flit_fifo
    import router_node_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  flit_t wr_data,
    input  logic  pop,
    output logic  empty,
    output logic  full,
    output flit_t head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    flit_t       mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/router_node.sv
// 2-D torus router node: +X/+Y inputs buffered per input, dimension-order
// routed, round-robin arbitrated onto registered +X/+Y outputs.
module router_node
    import router_node_pkg::*;
#(
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    router_node_if.slave ports
);
    localparam logic [3:0] MY_X = X_COORD[3:0];
    localparam logic [3:0] MY_Y = Y_COORD[3:0];

    flit_t  x_in, y_in, x_head, y_head;
    logic   x_empty, x_full, y_empty, y_full;
    logic   x_pop, y_pop;
    route_e x_route, y_route;
    logic   xo_req_x, xo_req_y, yo_req_x, yo_req_y;
    logic   xo_gnt_x, xo_gnt_y, yo_gnt_x, yo_gnt_y;
    src_e   xo_ptr, yo_ptr;
    flit_t  out_x_q, out_y_q;

    assign x_in = flit_t'(ports.in_xpos_ser);
    assign y_in = flit_t'(ports.in_ypos_ser);

    flit_fifo #(.DEPTH(FIFO_DEPTH)) u_x_fifo (
        .clk(clk), .rst(rst), .push(x_in.valid), .wr_data(x_in), .pop(x_pop),
        .empty(x_empty), .full(x_full), .head(x_head)
    );

    flit_fifo #(.DEPTH(FIFO_DEPTH)) u_y_fifo (
        .clk(clk), .rst(rst), .push(y_in.valid), .wr_data(y_in), .pop(y_pop),
        .empty(y_empty), .full(y_full), .head(y_head)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        x_route  = route_of(x_head, MY_X, MY_Y);
        y_route  = route_of(y_head, MY_X, MY_Y);
        xo_req_x = !x_empty && (x_route == ROUTE_X);
        xo_req_y = !y_empty && (y_route == ROUTE_X);
        yo_req_x = !x_empty && (x_route == ROUTE_Y);
        yo_req_y = !y_empty && (y_route == ROUTE_Y);

        // The pointer only matters on a tie; a lone requester always wins.
        xo_gnt_x = xo_req_x && (!xo_req_y || xo_ptr == SRC_X);
        xo_gnt_y = xo_req_y && !xo_gnt_x;
        yo_gnt_x = yo_req_x && (!yo_req_y || yo_ptr == SRC_X);
        yo_gnt_y = yo_req_y && !yo_gnt_x;

        x_pop = xo_gnt_x || yo_gnt_x || (!x_empty && x_route == ROUTE_EJECT);
        y_pop = xo_gnt_y || yo_gnt_y || (!y_empty && y_route == ROUTE_EJECT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_x_q <= '0;
            out_y_q <= '0;
            xo_ptr  <= SRC_X;
            yo_ptr  <= SRC_X;
        end else begin
            out_x_q <= xo_gnt_x ? x_head : (xo_gnt_y ? y_head : '0);
            out_y_q <= yo_gnt_x ? x_head : (yo_gnt_y ? y_head : '0);
            if (xo_req_x && xo_req_y) xo_ptr <= xo_gnt_x ? SRC_Y : SRC_X;
            if (yo_req_x && yo_req_y) yo_ptr <= yo_gnt_x ? SRC_Y : SRC_X;
        end
    end

    assign ports.out_xpos_ser = out_x_q;
    assign ports.out_ypos_ser = out_y_q;

endmodule

// File: tb/tb_router_node.sv
// Self-checking bench for router_node at (0,0): a queue-based reference model
// predicts each output cycle and a scoreboard compares it against the DUT.
module tb_router_node;
    import router_node_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    router_node_if ifc ();

    router_node #(.X_COORD(0), .Y_COORD(0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ports(ifc.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    flit_t m_qx[$];
    flit_t m_qy[$];
    bit    m_ptr_xo = 1'b0;
    bit    m_ptr_yo = 1'b0;

    // Scoreboard of expected per-cycle outputs, plus valid flits seen on each output.
    flit_t exp_x[$];
    flit_t exp_y[$];
    flit_t got_x[$];
    flit_t got_y[$];

    function automatic flit_t mk(logic [3:0] dx, logic [3:0] dy, logic [7:0] src, logic [31:0] pl);
        flit_t f;
        f.valid   = 1'b1;
        f.meta    = 33'h1_5A5A_0000 ^ {1'b0, pl};
        f.dst_x   = dx;
        f.dst_y   = dy;
        f.src     = src;
        f.payload = pl;
        return f;
    endfunction

    // 0: wants +X output, 1: wants +Y output, 2: eject (node is at 0,0).
    function automatic int want(flit_t f);
        if (f.dst_x != 4'd0) return 0;
        if (f.dst_y != 4'd0) return 1;
        return 2;
    endfunction

    task automatic model_step(input logic r, input flit_t fx, input flit_t fy);
        flit_t ox, oy;
        bit hx, hy, rxx, rxy, ryx, ryy, gxx, gxy, gyx, gyy, px, py;
        ox = '0;
        oy = '0;
        if (!r) begin
            m_qx.delete();
            m_qy.delete();
            m_ptr_xo = 1'b0;
            m_ptr_yo = 1'b0;
        end else begin
            hx  = (m_qx.size() > 0);
            hy  = (m_qy.size() > 0);
            rxx = hx && want(m_qx[0]) == 0;
            rxy = hy && want(m_qy[0]) == 0;
            ryx = hx && want(m_qx[0]) == 1;
            ryy = hy && want(m_qy[0]) == 1;
            gxx = 0; gxy = 0; gyx = 0; gyy = 0;
            if (rxx && rxy) begin
                if (m_ptr_xo == 1'b0) gxx = 1; else gxy = 1;
                m_ptr_xo = ~m_ptr_xo;
            end else begin
                gxx = rxx;
                gxy = rxy;
            end
            if (ryx && ryy) begin
                if (m_ptr_yo == 1'b0) gyx = 1; else gyy = 1;
                m_ptr_yo = ~m_ptr_yo;
            end else begin
                gyx = ryx;
                gyy = ryy;
            end
            if (gxx) ox = m_qx[0];
            if (gxy) ox = m_qy[0];
            if (gyx) oy = m_qx[0];
            if (gyy) oy = m_qy[0];
            px = gxx || gyx || (hx && want(m_qx[0]) == 2);
            py = gxy || gyy || (hy && want(m_qy[0]) == 2);
            if (px) void'(m_qx.pop_front());
            if (py) void'(m_qy.pop_front());
            if (fx.valid && m_qx.size() < DEPTH) m_qx.push_back(fx);
            if (fy.valid && m_qy.size() < DEPTH) m_qy.push_back(fy);
        end
        exp_x.push_back(ox);
        exp_y.push_back(oy);
    endtask

    // One clock: drive on the falling edge, predict, then compare just after the rising edge.
    task automatic cycle(input logic r, input flit_t fx, input flit_t fy);
        flit_t ex, ey, ax, ay;
        @(negedge clk);
        rst = r;
        ifc.in_xpos_ser = fx;
        ifc.in_ypos_ser = fy;
        model_step(r, fx, fy);
        @(posedge clk);
        #1;
        ax = flit_t'(ifc.out_xpos_ser);
        ay = flit_t'(ifc.out_ypos_ser);
        ex = exp_x.pop_front();
        ey = exp_y.pop_front();
        checks++;
        if (ax !== ex) begin
            errors++;
            $display("FAIL out_xpos_ser @%0t: got %h expected %h", $time, ax, ex);
        end
        checks++;
        if (ay !== ey) begin
            errors++;
            $display("FAIL out_ypos_ser @%0t: got %h expected %h", $time, ay, ey);
        end
        if (ax.valid) got_x.push_back(ax);
        if (ay.valid) got_y.push_back(ay);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, '0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, mk(4'd3, 4'd0, 8'd1, 32'(i)), mk(4'd0, 4'd2, 8'd2, 32'(i)));
        got_x.delete();
        got_y.delete();
        idle(3);
        checks++;
        if (got_x.size() != 0 || got_y.size() != 0) begin
            errors++;
            $display("FAIL reset_stale: got %0d/%0d flits expected 0/0", got_x.size(), got_y.size());
        end
    endtask

    task automatic test_forward();
        flit_t f;
        f = mk(4'd3, 4'd0, 8'd1, 32'd6);
        got_x.delete();
        got_y.delete();
        cycle(1'b1, f, '0);
        cycle(1'b1, '0, '0);
        checks++;
        if (got_x.size() != 1 || got_x[0] !== f || got_y.size() != 0) begin
            errors++;
            $display("FAIL forward: got %0d flits on X expected 1 of %h", got_x.size(), f);
        end
        idle(1);
    endtask

    task automatic test_y_route_eject();
        flit_t f;
        f = mk(4'd0, 4'd2, 8'd2, 32'd5);
        got_x.delete();
        got_y.delete();
        cycle(1'b1, '0, f);
        cycle(1'b1, mk(4'd0, 4'd0, 8'd1, 32'd9), mk(4'd0, 4'd0, 8'd2, 32'd9));
        idle(2);
        checks++;
        if (got_y.size() != 1 || got_y[0] !== f || got_x.size() != 0) begin
            errors++;
            $display("FAIL y_route_eject: got %0d X and %0d Y flits expected 0 and 1", got_x.size(), got_y.size());
        end
    endtask

    task automatic test_contention();
        logic [31:0] pls [4];
        pls = '{32'd6, 32'd5, 32'd4, 32'd3};
        got_x.delete();
        got_y.delete();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(4'd1, 4'd0, 8'd1, pls[i]), mk(4'd1, 4'd0, 8'd2, pls[i]));
        idle(6);
        checks++;
        if (got_x.size() != 8 || got_y.size() != 0) begin
            errors++;
            $display("FAIL contention_count: got %0d X flits expected 8", got_x.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (got_x[k].src !== 8'((k % 2) + 1) || got_x[k].payload !== pls[k / 2]) begin
                    errors++;
                    $display("FAIL contention_order[%0d]: got src %0d payload %0d expected src %0d payload %0d",
                             k, got_x[k].src, got_x[k].payload, (k % 2) + 1, pls[k / 2]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int last1, last2;
        got_x.delete();
        for (int i = 0; i < 12; i++) cycle(1'b1, mk(4'd1, 4'd1, 8'd1, 32'(i)), mk(4'd2, 4'd0, 8'd2, 32'(i)));
        idle(10);
        checks++;
        if (got_x.size() >= 24) begin
            errors++;
            $display("FAIL overflow_drop: got %0d delivered expected fewer than 24", got_x.size());
        end
        last1 = -1;
        last2 = -1;
        for (int k = 0; k < got_x.size(); k++) begin
            checks++;
            if (got_x[k].src == 8'd1 && int'(got_x[k].payload) > last1) last1 = int'(got_x[k].payload);
            else if (got_x[k].src == 8'd2 && int'(got_x[k].payload) > last2) last2 = int'(got_x[k].payload);
            else begin
                errors++;
                $display("FAIL overflow_order[%0d]: got src %0d payload %0d out of order", k, got_x[k].src, got_x[k].payload);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'd1, 4'd0, 8'd1, 32'(i)), mk(4'd1, 4'd0, 8'd2, 32'(i)));
        cycle(1'b0, '0, '0);
        got_x.delete();
        idle(4);
        checks++;
        if (got_x.size() != 0) begin
            errors++;
            $display("FAIL mid_reset: got %0d flits after reset expected 0", got_x.size());
        end
    endtask

    task automatic test_parallel();
        got_x.delete();
        got_y.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, mk(4'd2, 4'd0, 8'd1, 32'(100 + i)), mk(4'd0, 4'd3, 8'd2, 32'(200 + i)));
        idle(2);
        checks++;
        if (got_x.size() != 8 || got_y.size() != 8) begin
            errors++;
            $display("FAIL parallel: got %0d/%0d flits expected 8/8", got_x.size(), got_y.size());
        end
    endtask

    initial begin
        ifc.in_xpos_ser = '0;
        ifc.in_ypos_ser = '0;
        test_reset();
        test_forward();
        test_y_route_eject();
        test_contention();
        test_overflow();
        test_mid_reset();
        test_parallel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
